add_serial_arb: RTL



---
 rtl/add_serial_arb_if.sv | 34 +++
 rtl/add_serial_arb.sv | 101 ++++++++++
 2 files changed

// File: rtl/add_serial_arb_if.sv
// add_serial_arb_if: requester-side bus of the shared serial adder.
// Signals:
//   req     requester -> arb  level request per requester
//   a_flat  requester -> arb  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_flat  requester -> arb  operand B, same packing
//   ack     arb -> requester  one-hot pulse, operands captured
//   done    arb -> requester  one-hot pulse, result valid on out/cout
//   out     arb -> requester  sum
//   cout    arb -> requester  carry-out
//   busy    arb -> requester  engine occupied
//   gnt_id  arb -> requester  current or last owner
interface add_serial_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_flat;
    logic [NREQ*WIDTH-1:0] b_flat;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      out;
    logic                  cout;
    logic                  busy;
    logic [IDW-1:0]        gnt_id;
    modport master (
        output req, a_flat, b_flat,
        input  ack, done, out, cout, busy, gnt_id
    );
    modport slave (
        input  req, a_flat, b_flat,
        output ack, done, out, cout, busy, gnt_id
    );
endinterface

// File: rtl/add_serial_arb.sv
// add_serial_arb: round-robin arbiter sharing one LSB-first serial adder among NREQ requesters.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of add_serial_arb_if (req/a_flat/b_flat in; ack/done/out/cout/busy/gnt_id out)
module add_serial_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    add_serial_arb_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic [NREQ-1:0]  ack;
    logic [NREQ-1:0]  done;
    logic             carry;
    logic             cout;
    logic             sum;
    logic             maj;
    logic             last;
    // Scan from the highest offset down so the lowest offset from ptr wins;
    // IDW-bit addition wraps modulo NREQ because NREQ is a power of two.
    always_comb begin
        winner = ptr;
        idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + IDW'(i);
            if (bus.req[idx]) winner = idx;
        end
    end
    assign sum  = a_reg[0] ^ b_reg[0] ^ carry;
    assign maj  = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
    assign last = count == CW'(WIDTH - 1);
    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == IDLE ? (|bus.req ? ADD : IDLE) :
                    state == ADD  ? (last ? DONE : ADD) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            gnt_id <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            out    <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cout   <= 1'b0;
            ack    <= '0;
            done   <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            if (state == IDLE && |bus.req) begin
                a_reg  <= bus.a_flat[winner*WIDTH +: WIDTH];
                b_reg  <= bus.b_flat[winner*WIDTH +: WIDTH];
                carry  <= 1'b0;
                count  <= '0;
                out    <= '0;
                gnt_id <= winner;
                ack    <= NREQ'(1) << winner;
            end else if (state == ADD) begin
                carry <= maj;
                out   <= {sum, out[WIDTH-1:1]};
                a_reg <= a_reg >> 1;
                b_reg <= b_reg >> 1;
                count <= count + 1'b1;
                // Result and final carry land together with the done pulse.
                if (last) begin
                    done <= NREQ'(1) << gnt_id;
                    cout <= maj;
                end
            end else if (state == DONE) begin
                ptr <= gnt_id + 1'b1;
            end
        end
    end
    assign bus.ack    = ack;
    assign bus.done   = done;
    assign bus.out    = out;
    assign bus.cout   = cout;
    assign bus.busy   = state != IDLE;
    assign bus.gnt_id = gnt_id;
endmodule
